// File: rtl/program_loader_if.sv
// Signal bundle between the program loader and its environment: the byte stream,
// the instruction-memory write port and the load status/processor-reset outputs.
interface program_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              Start;
  logic [DATA_W-1:0] In_Data;
  logic              In_Valid;
  logic              In_Ready;
  logic              Imem_WE;
  logic [ADDR_W-1:0] Imem_Addr;
  logic [DATA_W-1:0] Imem_WData;
  logic              Cpu_Reset;
  logic              Busy;
  logic              Done;
  logic              Error;

  modport master (
    output Start, In_Data, In_Valid,
    input  In_Ready, Imem_WE, Imem_Addr, Imem_WData, Cpu_Reset, Busy, Done, Error
  );

  modport slave (
    input  Start, In_Data, In_Valid,
    output In_Ready, Imem_WE, Imem_Addr, Imem_WData, Cpu_Reset, Busy, Done, Error
  );
endinterface

// File: rtl/program_loader.sv
// Loads a framed byte stream (length, instructions, checksum) into instruction memory
// and keeps the processor core in reset until a frame with a good checksum completes.
module program_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic             Clk,
  input logic             Reset,
  program_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] count, count_next;
  logic [ADDR_W-1:0] len, len_next;
  logic [DATA_W-1:0] sum, sum_next;
  logic              xfer;
  logic              len_ok;

  logic              ready_q, ready_next;
  logic              we_q, we_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [DATA_W-1:0] wdata_q, wdata_next;
  logic              cpu_reset_q, cpu_reset_next;
  logic              done_q, done_next;
  logic              error_q, error_next;

  assign xfer   = bus.In_Valid & ready_q;
  assign len_ok = (bus.In_Data != '0) && (int'(bus.In_Data) <= DEPTH);

  always_comb begin
    state_next = state;
    count_next = count;
    len_next   = len;
    sum_next   = sum;
    we_next    = 1'b0;
    addr_next  = addr_q;
    wdata_next = wdata_q;

    case (state)
      IDLE, DONE, ERR: begin
        if (bus.Start) begin
          state_next = LEN;
          count_next = '0;
          sum_next   = '0;
        end
      end
      LEN: begin
        if (xfer) begin
          if (len_ok) begin
            len_next   = ADDR_W'(bus.In_Data);
            state_next = DATA;
          end else begin
            state_next = ERR;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          we_next    = 1'b1;
          addr_next  = count;
          wdata_next = bus.In_Data;
          sum_next   = sum + bus.In_Data;
          count_next = count + ADDR_W'(1);
          if (count == len - ADDR_W'(1)) state_next = CSUM;
        end
      end
      CSUM: begin
        if (xfer) state_next = (bus.In_Data == sum) ? DONE : ERR;
      end
      default: state_next = IDLE;
    endcase

    // Status outputs are derived from the next state so they are registered alongside it.
    ready_next     = (state_next == LEN) || (state_next == DATA) || (state_next == CSUM);
    done_next      = (state_next == DONE);
    error_next     = (state_next == ERR);
    cpu_reset_next = (state_next != DONE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= IDLE;
      count       <= '0;
      len         <= '0;
      sum         <= '0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      len         <= len_next;
      sum         <= sum_next;
      ready_q     <= ready_next;
      we_q        <= we_next;
      addr_q      <= addr_next;
      wdata_q     <= wdata_next;
      cpu_reset_q <= cpu_reset_next;
      done_q      <= done_next;
      error_q     <= error_next;
    end
  end

  assign bus.In_Ready   = ready_q;
  assign bus.Busy       = ready_q;
  assign bus.Imem_WE    = we_q;
  assign bus.Imem_Addr  = addr_q;
  assign bus.Imem_WData = wdata_q;
  assign bus.Cpu_Reset  = cpu_reset_q;
  assign bus.Done       = done_q;
  assign bus.Error      = error_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (DEPTH=16): frames, checksum/length errors,
// stalls, mid-load reset and Start handling.
module tb_program_loader;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];

  program_loader_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  program_loader #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) dut (
    .Clk  (clk),
    .Reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (bus.Imem_WE === 1'b1) begin
      wa.push_back(bus.Imem_Addr);
      wd.push_back(bus.Imem_WData);
      wc.push_back(cyc);
    end
  end

  // {Busy, Done, Error, Cpu_Reset}
  function automatic logic [3:0] status();
    return {bus.Busy, bus.Done, bus.Error, bus.Cpu_Reset};
  endfunction

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bus.In_Data  = b;
    bus.In_Valid = 1'b1;
    @(posedge clk); #1;
    bus.In_Valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [21:0] act;
    reset = 1'b0;
    idle(2);
    act = {bus.In_Ready, bus.Imem_WE, bus.Cpu_Reset, bus.Busy, bus.Done, bus.Error,
           bus.Imem_Addr, bus.Imem_WData};
    checks++;
    if (act !== {6'b001000, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h expected %h", act, {6'b001000, 16'h0000});
    end
    reset = 1'b1;
    idle(1);
  endtask

  task automatic test_good_frame();
    logic [7:0] ea[3] = '{8'h00, 8'h01, 8'h02};
    logic [7:0] ed[3] = '{8'h11, 8'h22, 8'h43};
    clear_log();
    pulse_start();
    checks++;
    if (status() !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL good_start_status: got %b expected 1001", status());
    end
    send(8'h03); send(8'h11); send(8'h22); send(8'h43); send(8'h76);
    checks++;
    if (status() !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL good_done_status: got %b expected 0100", status());
    end
    checks++;
    if (wa.size() !== 3) begin
      errors++;
      $display("[TB] FAIL good_write_count: got %0d expected 3", wa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i] || wc[i] !== wc[0] + i) begin
          errors++;
          $display("[TB] FAIL good_write_%0d: got (%h,%h,cyc+%0d) expected (%h,%h,cyc+%0d)",
                   i, wa[i], wd[i], wc[i] - wc[0], ea[i], ed[i], i);
        end
      end
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    pulse_start();
    send(8'h03); send(8'h11); send(8'h22); send(8'h43); send(8'h75);
    checks++;
    if (status() !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL badsum_status: got %b expected 0011", status());
    end
    checks++;
    if (wa.size() !== 3) begin
      errors++;
      $display("[TB] FAIL badsum_write_count: got %0d expected 3", wa.size());
    end
  endtask

  task automatic test_bad_length();
    logic [7:0] bad[2] = '{8'h00, 8'h11};
    for (int k = 0; k < 2; k++) begin
      clear_log();
      pulse_start();
      send(bad[k]);
      checks++;
      if (status() !== 4'b0011) begin
        errors++;
        $display("[TB] FAIL badlen_%h_status: got %b expected 0011", bad[k], status());
      end
      bus.In_Data  = 8'h55;
      bus.In_Valid = 1'b1;
      idle(2);
      bus.In_Valid = 1'b0;
      checks++;
      if (wa.size() !== 0 || bus.In_Ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL badlen_%h_no_write: got writes=%0d ready=%b expected writes=0 ready=0",
                 bad[k], wa.size(), bus.In_Ready);
      end
    end
  endtask

  task automatic test_max_length();
    logic [7:0] s = 8'h00;
    clear_log();
    pulse_start();
    send(8'h10);
    for (int i = 0; i < 16; i++) begin
      send(8'(i * 7 + 1));
      s = s + 8'(i * 7 + 1);
    end
    send(s);
    checks++;
    if (status() !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL maxlen_status: got %b expected 0100", status());
    end
    checks++;
    if (wa.size() !== 16) begin
      errors++;
      $display("[TB] FAIL maxlen_write_count: got %0d expected 16", wa.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (wa[i] !== 8'(i) || wd[i] !== 8'(i * 7 + 1)) begin
          errors++;
          $display("[TB] FAIL maxlen_write_%0d: got (%h,%h) expected (%h,%h)",
                   i, wa[i], wd[i], 8'(i), 8'(i * 7 + 1));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] ed[4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    clear_log();
    pulse_start();
    send(8'h04);
    for (int i = 0; i < 4; i++) begin
      send(ed[i]);
      if (i < 3) begin
        idle(2);
        checks++;
        if (bus.Imem_WE !== 1'b0 || status() !== 4'b1001) begin
          errors++;
          $display("[TB] FAIL stall_%0d_hold: got we=%b status=%b expected we=0 status=1001",
                   i, bus.Imem_WE, status());
        end
      end
    end
    send(8'hE6);
    checks++;
    if (status() !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL stall_done_status: got %b expected 0100", status());
    end
    checks++;
    if (wa.size() !== 4) begin
      errors++;
      $display("[TB] FAIL stall_write_count: got %0d expected 4", wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wa[i] !== 8'(i) || wd[i] !== ed[i]) begin
          errors++;
          $display("[TB] FAIL stall_write_%0d: got (%h,%h) expected (%h,%h)",
                   i, wa[i], wd[i], 8'(i), ed[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [21:0] act;
    pulse_start();
    send(8'h05); send(8'h01); send(8'h02);
    reset = 1'b0;
    idle(1);
    act = {bus.In_Ready, bus.Imem_WE, bus.Cpu_Reset, bus.Busy, bus.Done, bus.Error,
           bus.Imem_Addr, bus.Imem_WData};
    checks++;
    if (act !== {6'b001000, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL midreset_values: got %h expected %h", act, {6'b001000, 16'h0000});
    end
    reset = 1'b1;
    idle(1);
    clear_log();
    pulse_start();
    send(8'h05);
    for (int i = 1; i <= 5; i++) send(8'(i));
    send(8'h0F);
    checks++;
    if (status() !== 4'b0100 || wa.size() !== 5) begin
      errors++;
      $display("[TB] FAIL midreset_reload: got status=%b writes=%0d expected status=0100 writes=5",
               status(), wa.size());
    end else begin
      checks++;
      if (wa[4] !== 8'h04 || wd[4] !== 8'h05 || wa[0] !== 8'h00 || wd[0] !== 8'h01) begin
        errors++;
        $display("[TB] FAIL midreset_reload_data: got first (%h,%h) last (%h,%h) expected (00,01) (04,05)",
                 wa[0], wd[0], wa[4], wd[4]);
      end
    end
  endtask

  task automatic test_start_handling();
    clear_log();
    pulse_start();
    send(8'h03); send(8'h11);
    pulse_start();
    send(8'h22); send(8'h43); send(8'h76);
    checks++;
    if (status() !== 4'b0100 || wa.size() !== 3) begin
      errors++;
      $display("[TB] FAIL start_in_data: got status=%b writes=%0d expected status=0100 writes=3",
               status(), wa.size());
    end else begin
      checks++;
      if (wa[2] !== 8'h02 || wd[2] !== 8'h43) begin
        errors++;
        $display("[TB] FAIL start_in_data_addr: got (%h,%h) expected (02,43)", wa[2], wd[2]);
      end
    end
    pulse_start();
    checks++;
    if (status() !== 4'b1001 || bus.In_Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_in_done: got status=%b ready=%b expected status=1001 ready=1",
               status(), bus.In_Ready);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    reset        = 1'b0;
    bus.Start    = 1'b0;
    bus.In_Data  = 8'h00;
    bus.In_Valid = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_max_length();
    test_stall();
    test_reset_mid_load();
    test_start_handling();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
